// File: rtl/multicycle_cpu_core_ctrl.sv
// Multi-cycle core controller: owns PC, IR, writeback and retired registers and
// sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over variable-latency memory ports.
module multicycle_cpu_core_ctrl #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      OFF_W       = 13,
    parameter logic [XLEN-1:0]  PC_RESET    = '0,
    parameter int unsigned      MEM_TIMEOUT = 16,
    parameter int unsigned      CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   ir_out,
    input  logic              is_alu,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic              is_panic,
    input  logic              branch_taken,
    input  logic [OFF_W-1:0]  offset,
    input  logic [XLEN-1:0]   jump_target,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic [XLEN-1:0]   alu_result,
    output logic              reg_write,
    output logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   pc_out,
    output logic [CNT_W-1:0]  retired,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP
    } cls_t;

    state_t            state, state_d;
    cls_t              cls, cls_d;
    logic [XLEN-1:0]   pc_d, ir_d, wb_d;
    logic [CNT_W-1:0]  retired_d;
    logic              fault_d;
    logic [TO_W-1:0]   wait_cnt, wait_d;
    logic [XLEN-1:0]   pc_plus4, pc_branch, off_sext;
    logic              timeout_c;

    assign off_sext  = {{(XLEN-OFF_W){offset[OFF_W-1]}}, offset};
    assign pc_plus4  = pc_out + XLEN'(4);
    assign pc_branch = pc_out + off_sext;
    // Last waiting cycle: a ready seen in this same cycle still wins.
    assign timeout_c = (MEM_TIMEOUT != 0) && (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

    // Request and strobe outputs decode the registered state only.
    assign imem_req  = (state == S_FETCH) && !reset;
    assign imem_addr = pc_out;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && (cls == C_STORE);
    assign reg_write = (state == S_WRITEBACK);
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            cls      <= C_NONE;
            pc_out   <= PC_RESET;
            ir_out   <= '0;
            wb_data  <= '0;
            retired  <= '0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            cls      <= cls_d;
            pc_out   <= pc_d;
            ir_out   <= ir_d;
            wb_data  <= wb_d;
            retired  <= retired_d;
            fault    <= fault_d;
            wait_cnt <= wait_d;
        end
    end

    always_comb begin
        state_d   = state;
        cls_d     = cls;
        pc_d      = pc_out;
        ir_d      = ir_out;
        wb_d      = wb_data;
        retired_d = retired;
        fault_d   = fault;
        wait_d    = wait_cnt;

        case (state)
            S_FETCH: begin
                wait_d = wait_cnt + TO_W'(1);
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
                if (is_panic) begin
                    state_d = S_HALT;
                end else if (is_jump) begin
                    cls_d = C_JUMP;
                end else if (is_branch) begin
                    cls_d = C_BRANCH;
                end else if (is_alu) begin
                    cls_d = C_ALU;
                end else if (is_load) begin
                    cls_d = C_LOAD;
                end else if (is_store) begin
                    cls_d = C_STORE;
                end else begin
                    cls_d     = C_NONE;
                    pc_d      = pc_plus4;
                    retired_d = retired + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_EXECUTE: begin
                case (cls)
                    C_JUMP: begin
                        pc_d      = jump_target;
                        retired_d = retired + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    C_BRANCH: begin
                        pc_d      = branch_taken ? pc_branch : pc_plus4;
                        retired_d = retired + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    C_ALU: begin
                        wb_d    = alu_result;
                        state_d = S_WRITEBACK;
                    end
                    // Data address is muxed externally from alu_result.
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default: begin
                        pc_d      = pc_plus4;
                        retired_d = retired + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                wait_d = wait_cnt + TO_W'(1);
                if (dmem_ready) begin
                    if (cls == C_STORE) begin
                        pc_d      = pc_plus4;
                        retired_d = retired + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        wb_d    = dmem_rdata;
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WRITEBACK: begin
                pc_d      = pc_plus4;
                retired_d = retired + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Wait counter restarts whenever a new phase is entered.
        if (state_d != state) begin
            wait_d = '0;
        end
    end

endmodule

// File: doc/multicycle_cpu_core_ctrl.md
Name: multicycle_cpu_core_ctrl

Overview:
- Multi-cycle successor to the single-cycle core top: owns the PC and instruction register, and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK through an FSM.
- Fetch and data memory become variable-latency req/ready ports instead of combinational reads.
- Sits between the existing decoder, control module, register table and ALU. It generates every enable and mux select the datapath needs.
- Parametrised in data width, offset width, reset vector and memory-timeout depth. Adds a retired-instruction counter and a halt/fault indication.

Parameters:
- XLEN, 32, data/address width.
- OFF_W, 13, branch offset width; sign-extended to XLEN.
- PC_RESET, 0, PC value after reset.
- MEM_TIMEOUT, 16, max cycles waiting for any ready before fault; 0 disables the timeout.
- CNT_W, 32, retired-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request, held until imem_ready.
- imem_addr  out  XLEN  fetch address (= pc_out).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  XLEN  fetched instruction.
- ir_out  out  XLEN  instruction register, to decoder.
- is_alu, is_load, is_store, is_branch, is_jump, is_panic  in  1 each  decoded class from control module, valid from DECODE onward.
- branch_taken  in  1  comparator result, sampled in EXECUTE.
- offset  in  OFF_W  branch offset from decoder.
- jump_target  in  XLEN  register-A value.
- dmem_req  out  1  data access request, held until dmem_ready.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ready  in  1  access complete; load data valid this cycle.
- dmem_rdata  in  XLEN  load data.
- alu_result  in  XLEN  ALU output.
- reg_write  out  1  register-table write enable, exactly one cycle.
- wb_data  out  XLEN  writeback data.
- pc_out  out  XLEN  current PC.
- retired  out  CNT_W  instructions completed.
- halted  out  1  core stopped.
- fault  out  1  halt caused by timeout.

Behaviour:
- Reset (async, any state) gives: state FETCH, pc_out=PC_RESET, ir_out=0, retired=0. halted, fault, reg_write, imem_req, dmem_req and dmem_we are all 0. Outstanding memory requests are abandoned.
- FETCH: imem_req=1.
  - On a cycle with imem_ready=1: ir_out<=imem_rdata, go to DECODE.
  - imem_ready outside FETCH is ignored.
- DECODE: one cycle; the register table reads. Class inputs are sampled at exit, in priority order:
  - is_panic: go to HALT, retired unchanged, PC unchanged.
  - is_jump, is_branch, is_alu, is_load, is_store: go to EXECUTE.
  - no class set: treat as NOP, pc+=4, retired+=1, go to FETCH.
- EXECUTE: one cycle; exit depends on class.
  - Jump: pc<=jump_target, retired+=1, go to FETCH.
  - Branch: pc<=pc+sext(offset) if branch_taken, else pc+4; retired+=1, go to FETCH.
  - ALU: latch alu_result into the wb register, go to WRITEBACK.
  - Load/store: latch alu_result as the data address (external mux), go to MEM.
- MEM: dmem_req=1, dmem_we=is_store, held until dmem_ready.
  - Load: latch dmem_rdata, go to WRITEBACK.
  - Store: pc+=4, retired+=1, go to FETCH.
- WRITEBACK: reg_write=1 for exactly one cycle with wb_data stable; then pc+=4, retired+=1, go to FETCH.
- Latency with zero-wait memory (ready in the first request cycle), in cycles:
  - ALU: 4. Load: 5. Store: 4. Branch/jump: 3. NOP: 2.
  - Each wait cycle adds one.
- Timeout:
  - A wait counter clears on entering FETCH or MEM and increments each cycle ready=0.
  - When it reaches MEM_TIMEOUT: go to HALT with fault=1, drop the req, no register write, PC holds the faulting instruction address.
  - ready arriving in the same cycle as the count reaching MEM_TIMEOUT counts as success.
- HALT: absorbing until reset.
  - halted=1; all reqs and reg_write are 0; PC and retired frozen.
  - fault=1 only for timeout; 0 for panic.
- PC arithmetic is modulo 2^XLEN: 0xFFFFFFFC+4 = 0. sext(offset) is two's-complement; no alignment check.
- retired wraps modulo 2^CNT_W.
- req outputs are registered-state decodes (no combinational path from ready to req).

Test Plan:
- ALU sequence, zero-wait memory, PC_RESET=0: first instruction retires in cycle 4 with reg_write pulse width 1 and wb_data=alu_result. pc_out=4 and retired=1 afterwards.
- Load with dmem_ready delayed 3 cycles, dmem_rdata=0xDEADBEEF: dmem_req held 4 cycles, dmem_we=0. One reg_write with wb_data=0xDEADBEEF; total 8 cycles.
- Branch at pc=0x40, offset=-8 (13'h1FF8), taken: pc becomes 0x38. Same branch not taken: pc becomes 0x44. Both in 3 cycles with no reg_write.
- Jump with jump_target=0x100: pc=0x100 after 3 cycles; retired+1.
- is_panic at pc=0x20: halted=1, fault=0, pc stays 0x20. No further imem_req until reset; async reset mid-HALT gives pc=0 and FETCH on the next edge.
- MEM_TIMEOUT=16, imem_ready never asserted: halted=1 and fault=1 after 16 request cycles. Ready asserted exactly at cycle 16 completes normally.
